// File: rtl/pipe_delay.sv
// pipe_delay: DEPTH-stage valid-tracked delay line with flush and occupancy count; define PIPE_DELAY_GATE_DATA_EN to load data only on valid beats and zero q while invalid
module pipe_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // next state: flush clears valids and count but keeps data; en shifts every stage by one
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        occ_d   = occ_q;
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end else if (en) begin
            valid_d[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) valid_d[i] = valid_q[i-1];
`ifdef PIPE_DELAY_GATE_DATA_EN
            if (in_valid) data_d[0] = d;
            for (int i = 1; i < DEPTH; i++) if (valid_q[i-1]) data_d[i] = data_q[i-1];
`else
            data_d[0] = d;
            for (int i = 1; i < DEPTH; i++) data_d[i] = data_q[i-1];
`endif
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(valid_q[DEPTH-1]);
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    assign q_valid   = valid_q[DEPTH-1];
    assign occupancy = occ_q;
`ifdef PIPE_DELAY_GATE_DATA_EN
    assign q = valid_q[DEPTH-1] ? data_q[DEPTH-1] : '0;
`else
    assign q = data_q[DEPTH-1];
`endif

endmodule

// File: tb/tb_pipe_delay.sv
// tb_pipe_delay: vector table plus delay-line scoreboard for pipe_delay (DEPTH=3 and DEPTH=1)
module tb_pipe_delay;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, flush, in_valid;
    logic [7:0] d, q;
    logic       q_valid;
    logic [1:0] occ;

    logic rst1_n, en1, fl1, iv1, d1, q1, qv1, occ1;

    pipe_delay #(.WIDTH(8), .DEPTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
        .d(d), .q(q), .q_valid(q_valid), .occupancy(occ)
    );

    pipe_delay #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .en(en1), .flush(fl1), .in_valid(iv1),
        .d(d1), .q(q1), .q_valid(qv1), .occupancy(occ1)
    );

    typedef struct {
        logic       rst_n, en, flush, iv;
        logic [7:0] d, eq;
        logic       eqv;
        logic [1:0] eocc;
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic       qv;
        logic [1:0] occ;
    } exp_t;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } beat_t;

    vec_t  vt[$];
    exp_t  sb[$];
    beat_t pipe_m[$];
    int n_vec = 0;
    int n_bad = 0;
    int max_occ;

    function automatic void add(logic r, logic e, logic f, logic iv, logic [7:0] dd,
                                logic [7:0] eq, logic eqv, logic [1:0] eocc);
        vt.push_back('{r, e, f, iv, dd, eq, eqv, eocc});
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic e, logic f, logic iv, logic [7:0] dd);
        @(negedge clk);
        rst_n = r; en = e; flush = f; in_valid = iv; d = dd;
    endtask

    task automatic compare_front(string tag);
        exp_t ex;
        logic [7:0] eq;
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        eq = ex.q;
`ifdef PIPE_DELAY_GATE_DATA_EN
        if (!ex.qv) eq = '0;
`endif
        chk({tag, ".q_valid"}, 32'(q_valid), 32'(ex.qv));
        chk({tag, ".occ"}, 32'(occ), 32'(ex.occ));
        chk({tag, ".q"}, 32'(q), 32'(eq));
    endtask

    task automatic model_beat(string tag, logic iv, logic [7:0] dd);
        exp_t ex;
        int n;
        drive(1'b1, 1'b1, 1'b0, iv, dd);
        void'(pipe_m.pop_front());
        pipe_m.push_back('{iv, dd});
        n = 0;
        foreach (pipe_m[k]) n += int'(pipe_m[k].v);
        ex = '{pipe_m[0].d, pipe_m[0].v, 2'(n)};
        sb.push_back(ex);
        compare_front(tag);
        if (int'(occ) > max_occ) max_occ = int'(occ);
    endtask

    task automatic step1(string tag, logic r, logic e, logic iv, logic dd,
                         logic eq, logic eqv, logic eocc);
        @(negedge clk);
        rst1_n = r; en1 = e; iv1 = iv; d1 = dd;
        @(posedge clk);
        #1;
`ifdef PIPE_DELAY_GATE_DATA_EN
        if (!eqv) eq = 1'b0;
`endif
        chk({tag, ".q"}, 32'(q1), 32'(eq));
        chk({tag, ".q_valid"}, 32'(qv1), 32'(eqv));
        chk({tag, ".occ"}, 32'(occ1), 32'(eocc));
    endtask

    initial begin
        rst_n = 0; en = 0; flush = 0; in_valid = 0; d = '0;
        rst1_n = 0; en1 = 0; fl1 = 0; iv1 = 1; d1 = 0;
        add(0, 1, 0, 1, 8'hFF, 8'h00, 0, 0);
        add(0, 1, 0, 1, 8'hFF, 8'h00, 0, 0);
        add(1, 1, 0, 1, 8'hA5, 8'h00, 0, 1);
        add(1, 1, 0, 1, 8'hB1, 8'h00, 0, 2);
        add(1, 1, 0, 1, 8'hB2, 8'hA5, 1, 3);
        add(1, 1, 0, 0, 8'h00, 8'hB1, 1, 2);
        add(1, 1, 0, 0, 8'h00, 8'hB2, 1, 1);
        add(1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 1, 8'h11, 8'h00, 0, 1);
        add(1, 1, 0, 1, 8'h22, 8'h00, 0, 2);
        add(1, 1, 0, 1, 8'h33, 8'h11, 1, 3);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 8'hEE, 8'h11, 1, 3);
        add(1, 1, 0, 0, 8'h00, 8'h22, 1, 2);
        add(1, 1, 0, 0, 8'h00, 8'h33, 1, 1);
        add(1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 1, 8'h44, 8'h00, 0, 1);
        add(1, 1, 0, 1, 8'h55, 8'h00, 0, 2);
        add(1, 1, 0, 1, 8'h66, 8'h44, 1, 3);
        add(1, 1, 1, 1, 8'h77, 8'h44, 0, 0);
        add(1, 1, 0, 0, 8'h00, 8'h55, 0, 0);
        add(1, 1, 0, 0, 8'h00, 8'h66, 0, 0);
        add(1, 1, 0, 0, 8'h00, 8'h00, 0, 0);
        add(1, 1, 0, 1, 8'h81, 8'h00, 0, 1);
        add(1, 1, 0, 1, 8'h82, 8'h00, 0, 2);
        add(0, 1, 0, 1, 8'h83, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 8'h00, 8'h00, 0, 0);

        foreach (vt[i]) begin
            drive(vt[i].rst_n, vt[i].en, vt[i].flush, vt[i].iv, vt[i].d);
            sb.push_back('{vt[i].eq, vt[i].eqv, vt[i].eocc});
            compare_front($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 3; i++) pipe_m.push_back('{1'b0, 8'h00});
        for (int i = 0; i < 10; i++) model_beat($sformatf("stream%0d", i), 1'b1, 8'(i));
        for (int i = 0; i < 3; i++) model_beat($sformatf("drain%0d", i), 1'b0, 8'h00);

        max_occ = 0;
        for (int i = 0; i < 4; i++) model_beat($sformatf("bubble%0d", i), 1'(~i & 1), 8'(i + 1));
        for (int i = 0; i < 3; i++) model_beat($sformatf("bdrain%0d", i), 1'b0, 8'h00);
        chk("bubble.max_occ", 32'(max_occ), 32'd2);

        step1("d1.rst", 0, 1, 1, 1, 0, 0, 0);
        step1("d1.s0", 1, 1, 1, 1, 1, 1, 1);
        step1("d1.s1", 1, 1, 1, 0, 0, 1, 1);
        step1("d1.s2", 1, 0, 1, 1, 0, 1, 1);
        step1("d1.s3", 1, 1, 1, 0, 0, 1, 1);
        step1("d1.s4", 1, 1, 1, 1, 1, 1, 1);
        step1("d1.drain", 1, 1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_delay.md
Name: pipe_delay

Overview:
- Parametrised multi-stage pipeline delay line: WIDTH-bit data plus a valid bit per stage, DEPTH stages deep.
- Successor to the single-bit enabled DFF: generalised in width and depth, and adds valid tracking, a flush, and an occupancy count.
- Used to balance latency between datapath branches and to build stallable pipelines in course designs.

Parameters:
- WIDTH, 8, data bits per stage; legal range 1 or more.
- DEPTH, 4, number of register stages, equal to the latency in enabled cycles; legal range 1 or more. DEPTH=1 behaves as an enabled DFF with a valid bit.
- OCC_W, $clog2(DEPTH+1), width of the occupancy output; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- en  input  1  advance enable; when 0, all stages hold.
- flush  input  1  invalidate all stages; has priority over en.
- in_valid  input  1  marks d as a valid beat.
- d  input  WIDTH  input data.
- q  output  WIDTH  data of the last stage (DEPTH-1).
- q_valid  output  1  valid bit of the last stage.
- occupancy  output  OCC_W  number of stages currently holding a valid beat.

Behaviour:
- State: data_r[0..DEPTH-1] (WIDTH bits each), valid_r[0..DEPTH-1], occ_r (OCC_W bits). All registered on the rising edge of clk.
- Priority on each edge, highest first:
  - rst_n=0: all valid_r=0, all data_r=0, occ_r=0.
  - flush=1: all valid_r=0, occ_r=0; data_r holds. Any in_valid beat presented that cycle is dropped.
  - en=1: stage 0 takes {in_valid, d}; stage i takes stage i-1 for i=1..DEPTH-1.
  - otherwise: everything holds.
- Outputs: q=data_r[DEPTH-1], q_valid=valid_r[DEPTH-1], occupancy=occ_r. All are purely registered, with no combinational path from any input.
- Reset values: q=0, q_valid=0, occupancy=0, visible in the cycle after the first clock edge with rst_n=0.
- Latency: a beat accepted on edge N with en=1 appears at q on edge N+DEPTH-1 if en=1 on every intervening edge. Cycles with en=0 stretch the latency by one each.
- Occupancy:
  - When en=1 and there is no flush/reset: occ_r <= occ_r + in_valid - valid_r[DEPTH-1].
  - The result is always equal to the popcount of valid_r and never exceeds DEPTH, including when entering and leaving in the same cycle.
- Data movement: without the optional feature, data_r shifts unconditionally when en=1, regardless of valid. q may therefore show stale or garbage data while q_valid=0.
- Reset mid-stream: all in-flight beats are lost on the next edge; no partial state remains.
- Holding en=1 with in_valid=0 drains the pipe; occupancy counts down to 0 and stays there.
- DEPTH=1: q/q_valid follow {d,in_valid} one enabled edge later; occupancy is 0 or 1.

Optional Feature:
- Macro: PIPE_DELAY_GATE_DATA_EN.
- Defined:
  - data_r[i] loads only when the incoming valid bit for that stage is 1; otherwise it holds its old value, reducing toggling.
  - q is driven as 0 whenever q_valid=0. This gating is combinational on the registered values.
  - valid_r and occupancy behave as in the base design.
- Undefined:
  - Data shifts unconditionally as described in Behaviour.
  - q is raw data_r[DEPTH-1].

Test Plan (WIDTH=8, DEPTH=3 unless noted):
- Reset: rst_n=0 for 2 edges while en=1, in_valid=1, d=8'hFF -> q=0, q_valid=0, occupancy=0. Then rst_n=1, en=1, in_valid=1, d=8'hA5 on edge N -> q=8'hA5 and q_valid=1 after edge N+2; occupancy reads 1,2,3 over edges N..N+2.
- Stall: send 8'h11, 8'h22, 8'h33 back to back, then en=0 for 4 edges -> q=8'h11, q_valid=1 and occupancy=3 hold steady. With en=1 and in_valid=0 thereafter -> q shows 8'h22 then 8'h33; occupancy steps 3,2,1,0.
- Flush priority: pipe full, then flush=1, en=1, in_valid=1, d=8'h77 on one edge -> occupancy=0 and q_valid=0 on the following edge; 8'h77 never appears with q_valid=1.
- Steady stream: en=1, in_valid=1, d increments 0..9 -> q_valid=1 from the third edge onward; q equals d delayed by 3 edges; occupancy stays at 3 once full.
- Bubbles: in_valid pattern 1,0,1,0 with d=8'h01..8'h04 -> q_valid pattern 1,0,1,0 delayed by 3 edges; occupancy never exceeds 2. With PIPE_DELAY_GATE_DATA_EN defined -> q=0 on every beat where q_valid=0.
- DEPTH=1, WIDTH=1: replay the original DFF sequence: reset, then {d,en}={1,1},{0,1},{1,0},{0,1},{1,1} with in_valid=1 -> q=1,0,0 (held),0,1.
